// File: rtl/ifetch_prefetch_queue.sv
// Purpose: MIPS-32 instruction-fetch front end with a DEPTH-entry prefetch FIFO of {IR, NPC} pairs.
// Latency: a request in cycle t gives id_valid in cycle t+2; 1 instr/cycle sustained with id_ready high.
// Backpressure: id_valid/id_ready handshake; requests are credit-limited by count+inflight < DEPTH.
// Optional HLT_STOP_EN: a fetched HLT opcode (6'b111111) stops requests until redirect or reset.
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          AW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_rvalid,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_ir,
  output logic [31:0]   id_npc,
  output logic [31:0]   fetch_pc
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_pc_q, tag_pc_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   ir_q  [DEPTH];
  logic [31:0]   npc_q [DEPTH];

  logic          push, pop, stop_blk, credit_ok;
  logic [CW:0]   credit_used;

  // Only a response that belongs to the current stream is buffered.
  assign push = imem_rvalid && !drop_q;
  assign pop  = id_valid && id_ready;

`ifdef HLT_STOP_EN
  logic stopped_q, stopped_d;
  logic hlt_hit;
  // The HLT word blocks the request in its own push cycle so nothing past it is fetched.
  assign hlt_hit  = push && (imem_rdata[31:26] == 6'b111111);
  assign stop_blk = stopped_q || hlt_hit;

  // Stop flag: set by a pushed HLT, cleared only by redirect (or reset).
  always_comb begin
    stopped_d = stopped_q;
    if (redirect_valid)  stopped_d = 1'b0;
    else if (hlt_hit)    stopped_d = 1'b1;
  end

  // Stop flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stopped_q <= 1'b0;
    else        stopped_q <= stopped_d;
  end
`else
  assign stop_blk = 1'b0;
`endif

  // Conservative credit: an in-flight word already owns a slot; a same-cycle pop is not counted.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok   = credit_used < DEPTH_C;

  assign imem_req  = rst_n && !halt && !redirect_valid && !stop_blk && credit_ok;
  assign imem_addr = fetch_pc_q[AW-1:0];
  assign fetch_pc  = fetch_pc_q;
  assign id_valid  = (count_q != '0);
  assign id_ir     = ir_q[rd_ptr_q];
  assign id_npc    = npc_q[rd_ptr_q];

  // Next-state for PC, in-flight tracking and FIFO bookkeeping; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = inflight_q;
    drop_d     = 1'b0;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
      tag_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end else if (imem_rvalid) begin
      inflight_d = 1'b0;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_d     = inflight_q;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage: write the response word and its NPC at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= 32'd0;
        npc_q[i] <= 32'd0;
      end
    end else if (push) begin
      ir_q[wr_ptr_q]  <= imem_rdata;
      npc_q[wr_ptr_q] <= tag_pc_q + 32'd1;
    end
  end

  // Credit rule makes a push into a full FIFO unreachable.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
module tb_ifetch_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          AW       = 10;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          imem_rvalid = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          halt = 1'b0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_ir;
  logic [31:0]   id_npc;
  logic [31:0]   fetch_pc;

  ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_npc(id_npc),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int failures = 0;

  // Reference model: next PC, buffered {IR,NPC} pairs, outstanding request addresses.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  logic [31:0] m_pend[$];
  bit          m_stop;
  // Memory model state: the request seen in the previous cycle.
  bit          last_req;
  logic [AW-1:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_q.delete();
    m_pend.delete();
    m_stop = 1'b0;
    last_req = 1'b0;
    last_addr = '0;
  endtask

  // Asynchronous reset applied away from any clock edge; released just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_fetch_pc", fetch_pc, RESET_PC);
    chk("rst_id_ir", id_ir, 32'd0);
    chk("rst_id_npc", id_npc, 32'd0);
    model_reset();
    imem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle: drive memory response and inputs, compare all outputs with the model, advance the model.
  task automatic step(input bit h, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit resp, hit, exp_req, pop;
    logic [31:0] raddr, rdata;
    @(negedge clk);
    imem_rvalid    = last_req;
    imem_rdata     = mem[last_addr];
    halt           = h;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    resp  = (m_pend.size() > 0);
    raddr = resp ? m_pend[0] : 32'd0;
    rdata = mem[raddr[AW-1:0]];
    hit   = 1'b0;
`ifdef HLT_STOP_EN
    hit = resp && (rdata[31:26] == 6'b111111);
`endif
    exp_req = !h && !rv && !m_stop && !hit && ((m_q.size() + m_pend.size()) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("fetch_pc", fetch_pc, m_pc);
    chk("imem_addr", 32'(imem_addr), 32'(m_pc[AW-1:0]));
    chk("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("id_ir", id_ir, m_q[0][63:32]);
      chk("id_npc", id_npc, m_q[0][31:0]);
    end
    last_req  = imem_req;
    last_addr = imem_addr;
    pop = (m_q.size() != 0) && rdy;
    if (rv) begin
      m_q.delete();
      m_pend.delete();
      m_pc   = rpc;
      m_stop = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (resp) begin
        void'(m_pend.pop_front());
        m_q.push_back({rdata, raddr + 32'd1});
        if (hit) m_stop = 1'b1;
      end
      if (exp_req) begin
        m_pend.push_back(m_pc);
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h2801_0005 + i;
    model_reset();
    #2 do_reset();

    // First fetch after reset: request at t, decode sees it at t+2, then one per cycle.
    step(0, 1, 0, 0); chk("t1_req0", 32'(imem_req), 32'd1); chk("t1_addr0", 32'(imem_addr), 32'd0);
    step(0, 1, 0, 0); chk("t1_valid_early", 32'(id_valid), 32'd0);
    step(0, 1, 0, 0); chk("t1_ir0", id_ir, 32'h2801_0005); chk("t1_npc0", id_npc, 32'd1);
    step(0, 1, 0, 0); chk("t1_ir1", id_ir, 32'h2801_0006); chk("t1_npc1", id_npc, 32'd2);

    // Decode stall: FIFO fills to DEPTH and requests stop; release delivers in order.
    repeat (10) step(0, 0, 0, 0);
    chk("t2_full_noreq", 32'(imem_req), 32'd0);
    chk("t2_head_npc", id_npc, 32'd3);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      chk("t2_order_npc", id_npc, 32'd3 + 32'(k));
    end

    // Redirect with 3 buffered and one request in flight.
    repeat (10) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0); chk("t3_req_before", 32'(imem_req), 32'd1);
    step(0, 0, 1, 32'h20);
    step(0, 1, 0, 0); chk("t3_flushed", 32'(id_valid), 32'd0); chk("t3_addr", 32'(imem_addr), 32'h20);
    step(0, 1, 0, 0); chk("t3_stale_dropped", 32'(id_valid), 32'd0);
    step(0, 1, 0, 0); chk("t3_ir", id_ir, 32'h2801_0025); chk("t3_npc", id_npc, 32'h21);

    // Halt: no requests while high; drain and resumption checked by the model.
    repeat (5) begin
      step(1, 1, 0, 0);
      chk("t4_halt_noreq", 32'(imem_req), 32'd0);
    end
    repeat (6) step(0, 1, 0, 0);

    // PC wrap-around at the top of the 32-bit space.
    step(0, 1, 1, 32'hFFFF_FFFE);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0); chk("wrap_npc_top", id_npc, 32'hFFFF_FFFF);
    step(0, 1, 0, 0); chk("wrap_npc_zero", id_npc, 32'd0);

    // Reset with a full FIFO; restart from RESET_PC. Plant HLT at word 3.
    repeat (8) step(0, 0, 0, 0);
    chk("t5_full_before_rst", 32'(id_valid), 32'd1);
    mem[3] = 32'hFC00_0000;
    do_reset();
    step(0, 1, 0, 0); chk("t5_restart_addr", 32'(imem_addr), 32'd0);
    repeat (9) step(0, 1, 0, 0);
`ifdef HLT_STOP_EN
    chk("t6_stop_pc", fetch_pc, 32'd4);
    chk("t6_stop_noreq", 32'(imem_req), 32'd0);
`else
    chk("t6_past_hlt", 32'(fetch_pc > 32'd4), 32'd1);
`endif
    step(0, 1, 1, 32'h10);
    step(0, 1, 0, 0); chk("t6_resume_req", 32'(imem_req), 32'd1); chk("t6_resume_addr", 32'(imem_addr), 32'h10);
    repeat (4) step(0, 1, 0, 0);
    mem[3] = 32'h2801_0008;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 3) do_reset();
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
